// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port GPR file: default geometry, the hardwired
// zero register index and a port-slice offset helper.
package regfile_mp_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_RD_DEF = 2;
   localparam int REG_ZERO   = 0;

   // LSB offset of port p inside a flattened bus of w-bit lanes
   function automatic int slice_lsb(input int p, input int w);
      return p * w;
   endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: index mux, r0 forcing, busy lookup and, when
// REGFILE_BYPASS_EN is defined, same-cycle forwarding of the writeback data.
module regfile_rdport
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                                rst_n,
   input  logic [ADDR_W-1:0]                   idx_i,
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  mem_i,
   input  logic [(2**ADDR_W)-1:0]              pend_i,
   input  logic                                we_i,
   input  logic [ADDR_W-1:0]                   wr_idx_i,
   input  logic [DATA_W-1:0]                   wr_data_i,
   input  logic                                rsv_valid_i,
   input  logic [ADDR_W-1:0]                   rsv_idx_i,
   output logic [DATA_W-1:0]                   data_o,
   output logic                                busy_o
);

   logic is_zero;
   assign is_zero = (idx_i == ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
   logic byp_hit;
   assign byp_hit = rst_n && we_i && (wr_idx_i != ADDR_W'(REG_ZERO)) && (wr_idx_i == idx_i);
`else
   logic unused_byp;
   assign unused_byp = ^{rst_n, we_i, wr_idx_i, wr_data_i, rsv_valid_i, rsv_idx_i};
`endif

   always_comb begin
      data_o = is_zero ? '0 : mem_i[idx_i];
      busy_o = is_zero ? 1'b0 : pend_i[idx_i];
`ifdef REGFILE_BYPASS_EN
      // A same-index reserve means a new producer is already in flight
      if (byp_hit) begin
         data_o = wr_data_i;
         busy_o = rsv_valid_i && (rsv_idx_i == wr_idx_i);
      end
`endif
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with r0 hardwired to zero and a per-register pending
// scoreboard; optional write-to-read bypass via REGFILE_BYPASS_EN.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = NUM_RD_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_idx,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wr_idx,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_valid,
   input  logic [ADDR_W-1:0]        rsv_idx,
   output logic [ADDR_W:0]          pend_cnt
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] mem_q;
   logic [DEPTH-1:0]             pend_q, pend_d;
   logic [ADDR_W:0]              cnt_q, cnt_d;
   logic                         wr_ok, rsv_ok;

   assign wr_ok  = we && (wr_idx != ADDR_W'(REG_ZERO));
   assign rsv_ok = rsv_valid && (rsv_idx != ADDR_W'(REG_ZERO));

   // Reserve is applied after release so a same-index producer wins
   always_comb begin
      pend_d = pend_q;
      if (wr_ok)  pend_d[wr_idx]  = 1'b0;
      if (rsv_ok) pend_d[rsv_idx] = 1'b1;
      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++)
         cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '0;
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok) mem_q[wr_idx] <= wr_data;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_cnt = cnt_q;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport (
         .rst_n       (rst_n),
         .idx_i       (rd_idx[slice_lsb(p, ADDR_W) +: ADDR_W]),
         .mem_i       (mem_q),
         .pend_i      (pend_q),
         .we_i        (we),
         .wr_idx_i    (wr_idx),
         .wr_data_i   (wr_data),
         .rsv_valid_i (rsv_valid),
         .rsv_idx_i   (rsv_idx),
         .data_o      (rd_data[slice_lsb(p, DATA_W) +: DATA_W]),
         .busy_o      (rd_busy[p])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default geometry); expectations follow
// REGFILE_BYPASS_EN when the bench is compiled with it.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rd_idx;
   logic [127:0] rd_data;
   logic [1:0]  rd_busy;
   logic        we;
   logic [4:0]  wr_idx;
   logic [63:0] wr_data;
   logic        rsv_valid;
   logic [4:0]  rsv_idx;
   logic [5:0]  pend_cnt;

   int errs = 0;
   int nchk = 0;
   logic [63:0] expv [32];

   regfile_mp dut (
      .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
      .we(we), .wr_idx(wr_idx), .wr_data(wr_data), .rsv_valid(rsv_valid),
      .rsv_idx(rsv_idx), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      we = 1'b0;
      rsv_valid = 1'b0;
   endtask

   task automatic wr(input logic [4:0] idx, input logic [63:0] d);
      we = 1'b1; wr_idx = idx; wr_data = d;
      tick();
   endtask

   task automatic rsv(input logic [4:0] idx);
      rsv_valid = 1'b1; rsv_idx = idx;
      tick();
   endtask

   task automatic rd(input logic [4:0] i0, input logic [4:0] i1);
      rd_idx = {i1, i0};
      #1;
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; wr_idx = '0; wr_data = '0;
      rsv_valid = 1'b0; rsv_idx = '0; rd_idx = '0;
      foreach (expv[i]) expv[i] = '0;
      #2;
      chk("rst_data", rd_data[63:0], 64'd0);
      chk("rst_busy", {62'd0, rd_busy}, 64'd0);
      chk("rst_cnt", {58'd0, pend_cnt}, 64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // basic write / read, r0 discard
      wr(5'd1, 64'd25);
      rd(5'd1, 5'd1);
      chk("rd_p0_r1", rd_data[63:0], 64'd25);
      chk("rd_p1_r1", rd_data[127:64], 64'd25);
      wr(5'd0, 64'd100);
      rd(5'd0, 5'd0);
      chk("r0_zero", rd_data[63:0], 64'd0);
      chk("r0_busy", {62'd0, rd_busy}, 64'd0);

      // sweep r1..r31
      for (int i = 1; i < 32; i++) begin
         expv[i] = 64'($urandom_range(0, 31));
         wr(5'(i), expv[i]);
      end
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i));
         chk($sformatf("sweep_p0_r%0d", i), rd_data[63:0], expv[i]);
         chk($sformatf("sweep_p1_r%0d", 31 - i), rd_data[127:64], expv[31 - i]);
      end

      // scoreboard
      rsv(5'd7);
      rd(5'd7, 5'd7);
      chk("rsv7_busy", {62'd0, rd_busy}, 64'd3);
      chk("rsv7_cnt", {58'd0, pend_cnt}, 64'd1);
      wr(5'd7, 64'h55);
      rd(5'd7, 5'd0);
      chk("rel7_busy", {63'd0, rd_busy[0]}, 64'd0);
      chk("rel7_cnt", {58'd0, pend_cnt}, 64'd0);
      chk("rel7_data", rd_data[63:0], 64'h55);
      rsv_valid = 1'b1; rsv_idx = 5'd7;
      wr(5'd7, 64'h66);
      rd(5'd7, 5'd0);
      chk("rw7_data", rd_data[63:0], 64'h66);
      chk("rw7_busy", {63'd0, rd_busy[0]}, 64'd1);
      chk("rw7_cnt", {58'd0, pend_cnt}, 64'd1);
      wr(5'd7, 64'h77);
      expv[7] = 64'h77;
      chk("rel7b_cnt", {58'd0, pend_cnt}, 64'd0);

      // write-to-read bypass data and release
      rd(5'd3, 5'd0);
      we = 1'b1; wr_idx = 5'd3; wr_data = 64'hABCD;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_data", rd_data[63:0], 64'hABCD);
`else
      chk("byp_data", rd_data[63:0], expv[3]);
`endif
      tick();
      expv[3] = 64'hABCD;
      chk("byp_after", rd_data[63:0], 64'hABCD);
      rsv(5'd9);
      rd(5'd9, 5'd0);
      we = 1'b1; wr_idx = 5'd9; wr_data = 64'h9;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_busy", {63'd0, rd_busy[0]}, 64'd0);
`else
      chk("byp_busy", {63'd0, rd_busy[0]}, 64'd1);
`endif
      tick();
      chk("byp_busy_after", {63'd0, rd_busy[0]}, 64'd0);
      chk("byp_cnt", {58'd0, pend_cnt}, 64'd0);

      // fill scoreboard
      for (int i = 1; i < 32; i++) rsv(5'(i));
      chk("fill_cnt", {58'd0, pend_cnt}, 64'd31);
      rsv(5'd4);
      chk("rersv_cnt", {58'd0, pend_cnt}, 64'd31);
      rsv(5'd0);
      chk("rsv0_cnt", {58'd0, pend_cnt}, 64'd31);
      rd(5'd0, 5'd4);
      chk("rsv0_busy", {62'd0, rd_busy}, 64'd2);
      wr(5'd5, 64'd25);
      chk("rel5_cnt", {58'd0, pend_cnt}, 64'd30);
      rsv_valid = 1'b1; rsv_idx = 5'd5;
      wr(5'd6, 64'd60);
      rd(5'd5, 5'd6);
      chk("diff_busy", {62'd0, rd_busy}, 64'd1);
      chk("diff_cnt", {58'd0, pend_cnt}, 64'd30);
      chk("diff_data6", rd_data[127:64], 64'd60);

      // asynchronous reset mid-run with requests in flight
      rd(5'd5, 5'd6);
      rst_n = 1'b0;
      we = 1'b1; wr_idx = 5'd5; wr_data = 64'd99;
      rsv_valid = 1'b1; rsv_idx = 5'd5;
      #1;
      chk("mrst_data0", rd_data[63:0], 64'd0);
      chk("mrst_data1", rd_data[127:64], 64'd0);
      chk("mrst_busy", {62'd0, rd_busy}, 64'd0);
      chk("mrst_cnt", {58'd0, pend_cnt}, 64'd0);
      @(posedge clk); #1;
      we = 1'b0; rsv_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_data", rd_data[63:0], 64'd0);
      chk("post_rst_cnt", {58'd0, pend_cnt}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
